// File: rtl/pmic_rail_sequencer.sv
// Power-rail sequencer: brings NUM_RAILS regulators up in ascending order and down in
// descending order with tick-paced spacing, pg timeout supervision and fault shutdown.
module pmic_rail_sequencer #(
    parameter int NUM_RAILS  = 4,
    parameter int DLY_W      = 8,
    parameter int PG_TIMEOUT = 16
) (
    input  logic                 original_clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 pwr_req,
    input  logic [NUM_RAILS-1:0] pg,
    input  logic                 fault,
    input  logic [DLY_W-1:0]     dly_cfg,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 busy,
    output logic                 pwr_good,
    output logic                 err,
    output logic [2:0]           state
);
    localparam int IDX_W = $clog2(NUM_RAILS);
    localparam int TO_W  = $clog2(PG_TIMEOUT);
    localparam int CNT_W = (DLY_W > TO_W) ? DLY_W : TO_W;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(PG_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_RAILS - 1);
    localparam logic [IDX_W-1:0] IDX_NEXT = IDX_W'(NUM_RAILS - 2);

    typedef enum logic [2:0] {
        OFF      = 3'd0,
        UP_WAIT  = 3'd1,
        UP_DLY   = 3'd2,
        ON       = 3'd3,
        DOWN_DLY = 3'd4,
        FAULT    = 3'd5
    } state_t;

    state_t               st;
    logic [IDX_W-1:0]     idx;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     dly_lat;
    logic [NUM_RAILS-1:0] upto_idx;
    logic                 fault_hit;
    logic                 pg_lost;
    logic                 pg_timeout;
    logic                 abort;
    logic                 to_fault;
    logic                 step_down;

    assign state = st;

    always_comb begin
        upto_idx = '0;
        for (int k = 0; k < NUM_RAILS; k++) begin
            upto_idx[k] = (IDX_W'(k) <= idx);
        end
    end

    // Enabled rails above idx are excluded, so a rail switched off in DOWN_DLY may drop pg freely.
    assign fault_hit  = fault && (st != OFF) && (st != FAULT);
    assign pg_lost    = ((st == UP_DLY) || (st == ON) || (st == DOWN_DLY)) &&
                        (|(rail_en & ~pg & upto_idx));
    assign pg_timeout = (st == UP_WAIT) && !pg[idx] && tick && (cnt == TO_LAST);
    assign abort      = ((st == UP_WAIT) || (st == UP_DLY)) && !pwr_req;
    assign to_fault   = fault_hit || pg_lost || pg_timeout;
    assign step_down  = abort || ((st == DOWN_DLY) && (cnt == dly_lat));

    always_ff @(posedge original_clk) begin
        if (!rst_n) begin
            st       <= OFF;
            rail_en  <= '0;
            busy     <= 1'b0;
            pwr_good <= 1'b0;
            err      <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
        end else if (to_fault) begin
            st       <= FAULT;
            rail_en  <= '0;
            busy     <= 1'b0;
            pwr_good <= 1'b0;
            err      <= 1'b1;
        end else if (step_down) begin
            // Shared by a power-up abort and a completed power-down spacing interval.
            rail_en[idx] <= 1'b0;
            cnt          <= '0;
            pwr_good     <= 1'b0;
            if (idx == '0) begin
                st   <= OFF;
                busy <= 1'b0;
            end else begin
                st      <= DOWN_DLY;
                idx     <= idx - 1'b1;
                dly_lat <= CNT_W'(dly_cfg);
                busy    <= 1'b1;
            end
        end else begin
            case (st)
                OFF: begin
                    if (pwr_req && !fault) begin
                        st      <= UP_WAIT;
                        rail_en <= {{(NUM_RAILS-1){1'b0}}, 1'b1};
                        idx     <= '0;
                        cnt     <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                UP_WAIT: begin
                    if (pg[idx]) begin
                        if (idx == IDX_TOP) begin
                            st       <= ON;
                            busy     <= 1'b0;
                            pwr_good <= 1'b1;
                        end else begin
                            st      <= UP_DLY;
                            cnt     <= '0;
                            dly_lat <= CNT_W'(dly_cfg);
                        end
                    end else if (tick) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                UP_DLY: begin
                    if (cnt == dly_lat) begin
                        st                  <= UP_WAIT;
                        idx                 <= idx + 1'b1;
                        rail_en[idx + 1'b1] <= 1'b1;
                        cnt                 <= '0;
                    end else if (tick) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ON: begin
                    if (!pwr_req) begin
                        st                 <= DOWN_DLY;
                        rail_en[IDX_TOP]   <= 1'b0;
                        idx                <= IDX_NEXT;
                        cnt                <= '0;
                        dly_lat            <= CNT_W'(dly_cfg);
                        busy               <= 1'b1;
                        pwr_good           <= 1'b0;
                    end
                end
                DOWN_DLY: begin
                    if (tick) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FAULT: begin
                    if (!pwr_req && !fault) begin
                        st <= OFF;
                    end
                end
                default: st <= OFF;
            endcase
        end
    end
endmodule
